// File: rtl/uart_word_link.sv
// uart_word_link: packs UART bytes into words (RX FIFO) and splits words into bytes (TX FIFO + serializer).
// Ports: clk/rstb, rx_byte*, tx_byte*, word_in*, word_out*, tx_busy, rx_overflow, rx_timeout, err_clr, last_byte.
module uart_word_link #(
  parameter int WORD_BYTES   = 2,
  parameter int FIFO_DEPTH   = 4,
  parameter int TIMEOUT_CLKS = 8680,
  parameter int MSB_FIRST    = 1
) (
  input  logic                    clk,
  input  logic                    rstb,
  input  logic [7:0]              rx_byte,
  input  logic                    rx_byte_valid,
  output logic [7:0]              tx_byte,
  output logic                    tx_byte_valid,
  input  logic                    tx_byte_done,
  input  logic [8*WORD_BYTES-1:0] word_in,
  input  logic                    word_in_valid,
  output logic                    word_in_ready,
  output logic [8*WORD_BYTES-1:0] word_out,
  output logic                    word_out_valid,
  input  logic                    word_out_ready,
  output logic                    tx_busy,
  output logic                    rx_overflow,
  output logic                    rx_timeout,
  input  logic                    err_clr,
  output logic [7:0]              last_byte
);

  localparam int W  = 8 * WORD_BYTES;
  localparam int BW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);

  localparam logic [BW-1:0] LAST     = BW'(WORD_BYTES - 1);
  localparam logic [CW-1:0] FULL     = CW'(FIFO_DEPTH);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CLKS - 1);

  // Wire position of byte number idx inside a word.
  function automatic logic [BW-1:0] slot(input logic [BW-1:0] idx);
    return (MSB_FIRST != 0) ? LAST - idx : idx;
  endfunction

  function automatic logic [7:0] get_byte(
    input logic [W-1:0]  w,
    input logic [BW-1:0] idx
  );
    return w[int'(slot(idx))*8 +: 8];
  endfunction

  // ---------------- RX assembler ----------------
  logic [BW-1:0] r_cnt;
  logic [BW-1:0] w_cnt_eff;
  logic [BW-1:0] w_slot;
  logic [W-1:0]  r_acc;
  logic [W-1:0]  w_acc_nxt;
  logic [TW-1:0] r_tmo;
  logic          w_tmo_fire;
  logic          w_word_done;

  assign w_tmo_fire  = (r_cnt != '0) && (r_tmo == TMO_LAST);
  // A byte arriving as the timeout fires starts a fresh word.
  assign w_cnt_eff   = w_tmo_fire ? '0 : r_cnt;
  assign w_slot      = slot(w_cnt_eff);
  assign w_word_done = rx_byte_valid && (w_cnt_eff == LAST);

  always_comb begin
    w_acc_nxt = (w_cnt_eff == '0) ? '0 : r_acc;
    w_acc_nxt[int'(w_slot)*8 +: 8] = rx_byte;
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_cnt <= '0;
      r_acc <= '0;
      r_tmo <= '0;
    end else if (rx_byte_valid) begin
      r_acc <= w_acc_nxt;
      r_cnt <= w_word_done ? '0 : w_cnt_eff + 1'b1;
      r_tmo <= '0;
    end else if (w_tmo_fire) begin
      r_cnt <= '0;
      r_acc <= '0;
      r_tmo <= '0;
    end else if (r_cnt != '0) begin
      r_tmo <= r_tmo + 1'b1;
    end
  end

  // ---------------- RX FIFO ----------------
  logic [W-1:0]  r_rx_mem [FIFO_DEPTH];
  logic [AW-1:0] r_rx_wp;
  logic [AW-1:0] r_rx_rp;
  logic [CW-1:0] r_rx_n;
  logic          w_rx_pop;
  logic          w_rx_push;
  logic          w_rx_drop;
  logic          w_rx_full;

  assign w_rx_full = (r_rx_n == FULL);
  assign w_rx_pop  = word_out_valid && word_out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_rx_push = w_word_done && (!w_rx_full || w_rx_pop);
  assign w_rx_drop = w_word_done && w_rx_full && !w_rx_pop;

  always_ff @(posedge clk) begin
    if (w_rx_push) r_rx_mem[r_rx_wp] <= w_acc_nxt;
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_rx_wp <= '0;
      r_rx_rp <= '0;
      r_rx_n  <= '0;
    end else begin
      if (w_rx_push) r_rx_wp <= r_rx_wp + 1'b1;
      if (w_rx_pop)  r_rx_rp <= r_rx_rp + 1'b1;
      if (w_rx_push && !w_rx_pop)      r_rx_n <= r_rx_n + 1'b1;
      else if (!w_rx_push && w_rx_pop) r_rx_n <= r_rx_n - 1'b1;
    end
  end

  assign word_out_valid = (r_rx_n != '0);
  assign word_out       = word_out_valid ? r_rx_mem[r_rx_rp] : '0;

  // ---------------- status ----------------
  logic       r_ovf;
  logic       r_tmo_flag;
  logic [7:0] r_last;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_ovf      <= 1'b0;
      r_tmo_flag <= 1'b0;
      r_last     <= 8'haa;
    end else begin
      // New error events take priority over err_clr.
      if (w_rx_drop)    r_ovf <= 1'b1;
      else if (err_clr) r_ovf <= 1'b0;
      if (w_tmo_fire)   r_tmo_flag <= 1'b1;
      else if (err_clr) r_tmo_flag <= 1'b0;
      if (rx_byte_valid) r_last <= rx_byte;
    end
  end

  assign rx_overflow = r_ovf;
  assign rx_timeout  = r_tmo_flag;
  assign last_byte   = r_last;

  // ---------------- TX FIFO ----------------
  logic [W-1:0]  r_tx_mem [FIFO_DEPTH];
  logic [AW-1:0] r_tx_wp;
  logic [AW-1:0] r_tx_rp;
  logic [CW-1:0] r_tx_n;
  logic          r_live;
  logic          w_tx_push;
  logic          w_tx_pop;
  logic [W-1:0]  w_tx_head;

  // r_live keeps word_in_ready low until the first clock after reset.
  assign word_in_ready = r_live && (r_tx_n != FULL);
  assign w_tx_push     = word_in_valid && word_in_ready;
  assign w_tx_head     = r_tx_mem[r_tx_rp];

  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wp] <= word_in;
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_live  <= 1'b0;
      r_tx_wp <= '0;
      r_tx_rp <= '0;
      r_tx_n  <= '0;
    end else begin
      r_live <= 1'b1;
      if (w_tx_push) r_tx_wp <= r_tx_wp + 1'b1;
      if (w_tx_pop)  r_tx_rp <= r_tx_rp + 1'b1;
      if (w_tx_push && !w_tx_pop)      r_tx_n <= r_tx_n + 1'b1;
      else if (!w_tx_push && w_tx_pop) r_tx_n <= r_tx_n - 1'b1;
    end
  end

  // ---------------- serializer ----------------
  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_WAIT
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          w_load_next;
  logic [W-1:0]  r_tx_word;
  logic [BW-1:0] r_bidx;
  logic [BW-1:0] w_bidx_nxt;
  logic [7:0]    r_tx_byte;

  assign w_bidx_nxt = r_bidx + 1'b1;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tx_pop    = 1'b0;
    w_load_next = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (r_tx_n != '0) begin
          w_state_nxt = S_SEND;
          w_tx_pop    = 1'b1;
        end
      end
      S_SEND: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (tx_byte_done) begin
          if (r_bidx == LAST) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_SEND;
            w_load_next = 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // tx_byte only changes when entering SEND, so it is stable through WAIT.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_tx_word <= '0;
      r_bidx    <= '0;
      r_tx_byte <= '0;
    end else if (w_tx_pop) begin
      r_tx_word <= w_tx_head;
      r_bidx    <= '0;
      r_tx_byte <= get_byte(w_tx_head, '0);
    end else if (w_load_next) begin
      r_bidx    <= w_bidx_nxt;
      r_tx_byte <= get_byte(r_tx_word, w_bidx_nxt);
    end
  end

  assign tx_byte       = r_tx_byte;
  assign tx_byte_valid = (r_state == S_SEND);
  assign tx_busy       = (r_state != S_IDLE) || (r_tx_n != '0);

endmodule

// File: tb/tb_uart_word_link.sv
// tb_uart_word_link: directed checks of uart_word_link.
// u0 default, u1 MSB_FIRST=0 (shares u0 inputs), u2 WORD_BYTES=4.
module tb_uart_word_link;

  localparam int TMO = 8680;

  logic        clk = 1'b0;
  logic        rstb;
  logic [7:0]  rx_byte;
  logic        rx_v;
  logic        tx_done;
  logic [15:0] win;
  logic        win_v;
  logic        wout_rdy;
  logic        err_clr;

  logic [7:0]  a_txb, b_txb, c_txb;
  logic        a_txv, b_txv, c_txv;
  logic        a_wrdy, b_wrdy, c_wrdy;
  logic [15:0] a_wout, b_wout;
  logic [31:0] c_wout;
  logic        a_woutv, b_woutv, c_woutv;
  logic        a_busy, b_busy, c_busy;
  logic        a_ovf, b_ovf, c_ovf;
  logic        a_tmo, b_tmo, c_tmo;
  logic [7:0]  a_last, b_last, c_last;

  logic [31:0] c_win;
  logic        c_win_v;
  logic        c_done;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  uart_word_link u0 (
    .clk(clk), .rstb(rstb),
    .rx_byte(rx_byte), .rx_byte_valid(rx_v),
    .tx_byte(a_txb), .tx_byte_valid(a_txv), .tx_byte_done(tx_done),
    .word_in(win), .word_in_valid(win_v), .word_in_ready(a_wrdy),
    .word_out(a_wout), .word_out_valid(a_woutv), .word_out_ready(wout_rdy),
    .tx_busy(a_busy), .rx_overflow(a_ovf), .rx_timeout(a_tmo),
    .err_clr(err_clr), .last_byte(a_last)
  );

  uart_word_link #(.MSB_FIRST(0)) u1 (
    .clk(clk), .rstb(rstb),
    .rx_byte(rx_byte), .rx_byte_valid(rx_v),
    .tx_byte(b_txb), .tx_byte_valid(b_txv), .tx_byte_done(tx_done),
    .word_in(win), .word_in_valid(win_v), .word_in_ready(b_wrdy),
    .word_out(b_wout), .word_out_valid(b_woutv), .word_out_ready(wout_rdy),
    .tx_busy(b_busy), .rx_overflow(b_ovf), .rx_timeout(b_tmo),
    .err_clr(err_clr), .last_byte(b_last)
  );

  uart_word_link #(.WORD_BYTES(4)) u2 (
    .clk(clk), .rstb(rstb),
    .rx_byte(rx_byte), .rx_byte_valid(rx_v),
    .tx_byte(c_txb), .tx_byte_valid(c_txv), .tx_byte_done(c_done),
    .word_in(c_win), .word_in_valid(c_win_v), .word_in_ready(c_wrdy),
    .word_out(c_wout), .word_out_valid(c_woutv), .word_out_ready(wout_rdy),
    .tx_busy(c_busy), .rx_overflow(c_ovf), .rx_timeout(c_tmo),
    .err_clr(err_clr), .last_byte(c_last)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_byte = b;
    rx_v    = 1'b1;
    tick();
    rx_v    = 1'b0;
  endtask

  task automatic pop();
    wout_rdy = 1'b1;
    tick();
    wout_rdy = 1'b0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  logic [7:0] exp_c [4];
  int         stale;

  initial begin
    exp_c   = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    rstb    = 1'b0;
    rx_byte = '0;
    rx_v    = 1'b0;
    tx_done = 1'b0;
    win     = '0;
    win_v   = 1'b0;
    wout_rdy = 1'b0;
    err_clr = 1'b0;
    c_win   = '0;
    c_win_v = 1'b0;
    c_done  = 1'b0;
    stale   = 0;

    // reset values
    tick();
    tick();
    chk("rst_txb", a_txb, 8'h00);
    chk("rst_txv", a_txv, 1'b0);
    chk("rst_wrdy", a_wrdy, 1'b0);
    chk("rst_wout", a_wout, 16'h0);
    chk("rst_woutv", a_woutv, 1'b0);
    chk("rst_busy", a_busy, 1'b0);
    chk("rst_flags", {a_ovf, a_tmo}, 2'b00);
    chk("rst_last", a_last, 8'haa);
    rstb = 1'b1;
    tick();
    chk("wrdy_after_rst", a_wrdy, 1'b1);

    // RX word assembly, both byte orders
    send_byte(8'h12);
    chk("last_12", a_last, 8'h12);
    chk("woutv_partial", a_woutv, 1'b0);
    send_byte(8'h34);
    chk("woutv_1", a_woutv, 1'b1);
    chk("wout_msb", a_wout, 16'h1234);
    chk("wout_lsb", b_wout, 16'h3412);
    tick();
    chk("wout_hold", a_wout, 16'h1234);
    pop();
    chk("woutv_popped", a_woutv, 1'b0);

    // TX word 16'hABCD
    win   = 16'hABCD;
    win_v = 1'b1;
    tick();
    win_v = 1'b0;
    chk("tx_n1_v", a_txv, 1'b0);
    chk("tx_n1_busy", a_busy, 1'b1);
    tick();
    chk("tx_n2_v", a_txv, 1'b1);
    chk("tx_b0", a_txb, 8'hAB);
    chk("tx_b0_lsb", b_txb, 8'hCD);
    tick();
    chk("tx_wait_v", a_txv, 1'b0);
    chk("tx_wait_hold", a_txb, 8'hAB);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk("tx_b1_v", a_txv, 1'b1);
    chk("tx_b1", a_txb, 8'hCD);
    chk("tx_b1_lsb", b_txb, 8'hAB);
    tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk("tx_done_busy", a_busy, 1'b0);
    chk("tx_done_v", a_txv, 1'b0);

    // RX overflow: 5 words with no pops
    for (int i = 0; i < 5; i++) begin
      send_byte(8'(8'h10 + i));
      send_byte(8'(8'h20 + i));
      if (i == 3) chk("ovf_before", a_ovf, 1'b0);
    end
    chk("ovf_set", a_ovf, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk("ovf_order", a_wout, {8'(8'h10 + i), 8'(8'h20 + i)});
      pop();
    end
    chk("ovf_drop5", a_woutv, 1'b0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("ovf_clr", a_ovf, 1'b0);

    // RX timeout on a partial word
    send_byte(8'h55);
    repeat (TMO - 2) tick();
    chk("tmo_early", a_tmo, 1'b0);
    repeat (4) tick();
    chk("tmo_set", a_tmo, 1'b1);
    chk("tmo_noword", a_woutv, 1'b0);
    send_byte(8'h01);
    send_byte(8'h02);
    chk("tmo_next_v", a_woutv, 1'b1);
    chk("tmo_next", a_wout, 16'h0102);
    pop();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("tmo_clr", a_tmo, 1'b0);

    // 4-byte words with stalled transmitter
    c_win   = 32'hDEADBEEF;
    c_win_v = 1'b1;
    tick();
    c_win = 32'h11111111;
    tick();
    chk("c_b0_v", c_txv, 1'b1);
    chk("c_b0", c_txb, exp_c[0]);
    c_win = 32'h22222222;
    tick();
    c_win = 32'h33333333;
    tick();
    c_win = 32'h44444444;
    tick();
    c_win_v = 1'b0;
    chk("c_full", c_wrdy, 1'b0);
    for (int i = 1; i < 4; i++) begin
      c_done = 1'b1;
      tick();
      c_done = 1'b0;
      chk("c_bi_v", c_txv, 1'b1);
      chk("c_bi", c_txb, exp_c[i]);
      tick();
    end

    // reset mid-TX (u0, u2) and mid-RX word
    win   = 16'h5A5A;
    win_v = 1'b1;
    tick();
    win_v = 1'b0;
    tick();
    tick();
    send_byte(8'h99);
    chk("pre_rst_busy", a_busy, 1'b1);
    #2;
    rstb = 1'b0;
    #1;
    chk("mrst_txv", {a_txv, c_txv}, 2'b00);
    chk("mrst_txb", {a_txb, c_txb}, 16'h0);
    chk("mrst_busy", {a_busy, c_busy}, 2'b00);
    chk("mrst_wrdy", a_wrdy, 1'b0);
    chk("mrst_woutv", a_woutv, 1'b0);
    chk("mrst_last", a_last, 8'haa);
    tick();
    rstb = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tx_done = i[0];
      c_done  = i[0];
      tick();
      if (a_txv || c_txv || a_busy || c_busy) stale++;
    end
    tx_done = 1'b0;
    c_done  = 1'b0;
    chk("no_stale_tx", stale, 0);
    send_byte(8'h77);
    send_byte(8'h88);
    chk("post_rst_word", a_wout, 16'h7788);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
